// File: rtl/ff_response_checker.sv
// Checks a flip-flop's q (and optionally qbar) response against a delayed copy of its stimulus.
// Optional qbar/q consistency check: define FF_RESPONSE_CHECKER_QBAR_CHECK_EN.
module ff_response_checker #(
  parameter int NUM_SAMPLES = 16,
  parameter int LATENCY     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       d_ref,
  input  logic       q_in,
  input  logic       qbar_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] mismatch_cnt,
  output logic       cmp_err
);

  typedef enum logic [1:0] {IDLE, ARM, CHECK, DONE} state_t;

  localparam logic [7:0] NUM_SAMPLES_W = 8'(NUM_SAMPLES);
  localparam logic [2:0] LAST_ARM      = 3'(LATENCY - 1);

  state_t             state, state_nxt;
  logic [LATENCY-1:0] exp_pipe;
  logic               exp_q;
  logic [7:0]         sample_cnt;
  logic [2:0]         arm_cnt;
  logic               arm_last, check_last, q_miss;

  assign exp_q      = exp_pipe[LATENCY-1];
  assign q_miss     = (q_in != exp_q);
  assign arm_last   = (arm_cnt == LAST_ARM);
  assign check_last = ((sample_cnt + 8'd1) == NUM_SAMPLES_W);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = ARM;
      ARM: begin
        busy = 1'b1;
        if (arm_last) state_nxt = CHECK;
      end
      CHECK: begin
        busy = 1'b1;
        if (check_last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Expected-value pipeline runs in every state so it is primed once ARM ends.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exp_pipe <= '0;
    end else begin
      exp_pipe[0] <= d_ref;
      for (int i = 1; i < LATENCY; i++) exp_pipe[i] <= exp_pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample_cnt   <= '0;
      arm_cnt      <= '0;
      mismatch_cnt <= '0;
      pass         <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sample_cnt   <= '0;
          arm_cnt      <= '0;
          mismatch_cnt <= '0;
          pass         <= 1'b0;
        end
        ARM: arm_cnt <= arm_cnt + 3'd1;
        CHECK: begin
          sample_cnt <= sample_cnt + 8'd1;
          if (q_miss && mismatch_cnt != 8'hFF) mismatch_cnt <= mismatch_cnt + 8'd1;
        end
        // mismatch_cnt already includes the final CHECK cycle here.
        DONE: pass <= (mismatch_cnt == 8'd0) && !cmp_err;
        default: ;
      endcase
    end
  end

`ifdef FF_RESPONSE_CHECKER_QBAR_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                          cmp_err <= 1'b0;
    else if (state == IDLE && start)     cmp_err <= 1'b0;
    else if (state == CHECK && qbar_in == q_in) cmp_err <= 1'b1;
  end
`else
  logic unused_qbar;
  assign unused_qbar = qbar_in;
  assign cmp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_ff_response_checker.sv
// Directed bench for ff_response_checker: three instances (default, 255 samples, latency 3)
// with a scoreboard of expected run results popped on each done pulse.
module tb_ff_response_checker;

`ifdef FF_RESPONSE_CHECKER_QBAR_CHECK_EN
  localparam logic QC = 1'b1;
`else
  localparam logic QC = 1'b0;
`endif

  logic       clk = 1'b0, rst_n = 1'b0, d_ref = 1'b0;
  logic [2:0] start_a = '0;
  logic       force0 = 1'b0, qbar_eq = 1'b0;
  logic       q1d;
  logic [2:0] q3d;
  logic [2:0] q_a, qb_a, busy_a, done_a, pass_a, cerr_a;
  logic [7:0] mcnt0, mcnt1, mcnt2;
  int total = 0, bad = 0, since_start = 0, ph = 0;

  typedef struct {int id; int lat; int mcnt; int pas; int cerr;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  // Ideal flip-flops under test: one-stage and three-stage delays of d_ref.
  always @(posedge clk) begin
    if (!rst_n) begin q1d <= 1'b0; q3d <= '0; end
    else begin q1d <= d_ref; q3d <= {q3d[1:0], d_ref}; end
  end

  assign q_a[0]    = force0 ? 1'b0 : q1d;
  assign q_a[1]    = ~q1d;
  assign q_a[2]    = q3d[2];
  assign qb_a[0]   = qbar_eq ? q_a[0] : ~q_a[0];
  assign qb_a[2:1] = ~q_a[2:1];

  ff_response_checker u0 (
    .clk(clk), .rst_n(rst_n), .start(start_a[0]), .d_ref(d_ref), .q_in(q_a[0]), .qbar_in(qb_a[0]),
    .busy(busy_a[0]), .done(done_a[0]), .pass(pass_a[0]), .mismatch_cnt(mcnt0), .cmp_err(cerr_a[0]));
  ff_response_checker #(.NUM_SAMPLES(255)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_a[1]), .d_ref(d_ref), .q_in(q_a[1]), .qbar_in(qb_a[1]),
    .busy(busy_a[1]), .done(done_a[1]), .pass(pass_a[1]), .mismatch_cnt(mcnt1), .cmp_err(cerr_a[1]));
  ff_response_checker #(.LATENCY(3)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_a[2]), .d_ref(d_ref), .q_in(q_a[2]), .qbar_in(qb_a[2]),
    .busy(busy_a[2]), .done(done_a[2]), .pass(pass_a[2]), .mismatch_cnt(mcnt2), .cmp_err(cerr_a[2]));

  function automatic int mcnt_of(input int id);
    case (id)
      0: return int'(mcnt0);
      1: return int'(mcnt1);
      default: return int'(mcnt2);
    endcase
  endfunction

  // d_ref toggles every 2 cycles; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk); #1;
    since_start++;
    ph++;
    if (ph % 2 == 0) d_ref = ~d_ref;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic kick(input int id, input int lat, input int mcnt, input int pas, input int cerr,
                      input bit push);
    exp_t e;
    e = '{id: id, lat: lat, mcnt: mcnt, pas: pas, cerr: cerr};
    if (push) sb.push_back(e);
    start_a[id] = 1'b1;
    since_start = 0;
    tick();
    start_a[id] = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    exp_t e;
    e = sb.pop_front();
    while (done_a[e.id] !== 1'b1 && since_start < 400) tick();
    chk({tag, "_done_seen"}, int'(done_a[e.id]), 1);
    chk({tag, "_latency"}, since_start, e.lat);
    chk({tag, "_mcnt"}, mcnt_of(e.id), e.mcnt);
    tick();
    chk({tag, "_done_1cyc"}, int'(done_a[e.id]), 0);
    chk({tag, "_busy_idle"}, int'(busy_a[e.id]), 0);
    chk({tag, "_pass"}, int'(pass_a[e.id]), e.pas);
    chk({tag, "_cmp_err"}, int'(cerr_a[e.id]), e.cerr);
  endtask

  initial begin
    int nd;
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      chk("rst_busy", int'(busy_a[i]), 0);
      chk("rst_done", int'(done_a[i]), 0);
      chk("rst_pass", int'(pass_a[i]), 0);
      chk("rst_cerr", int'(cerr_a[i]), 0);
      chk("rst_mcnt", mcnt_of(i), 0);
    end
    rst_n = 1'b1;
    repeat (2) tick();

    // Ideal DFF: done 18 cycles after start, clean pass.
    kick(0, 18, 0, 1, 0, 1);
    chk("ideal_busy_arm", int'(busy_a[0]), 1);
    wait_done("ideal");

    // q stuck at 0 against a 50% duty stimulus: half the samples miss; results hold in IDLE.
    force0 = 1'b1;
    kick(0, 18, 8, 0, 0, 1);
    wait_done("stuck0");
    repeat (3) tick();
    chk("hold_mcnt", mcnt_of(0), 8);
    chk("hold_pass", int'(pass_a[0]), 0);
    force0 = 1'b0;

    // Every one of 255 samples wrong: counter tops out at 255.
    kick(1, 257, 255, 0, 0, 1);
    wait_done("sat255");

    // qbar equals q for one CHECK cycle.
    kick(0, 18, 0, QC ? 0 : 1, QC ? 1 : 0, 1);
    repeat (3) tick();
    qbar_eq = 1'b1;
    tick();
    qbar_eq = 1'b0;
    wait_done("qbar");
    repeat (2) tick();
    chk("qbar_sticky", int'(cerr_a[0]), QC ? 1 : 0);
    kick(0, 18, 0, 1, 0, 1);
    chk("qbar_clr_on_start", int'(cerr_a[0]), 0);
    wait_done("after_qbar");

    // Reset on the 5th CHECK cycle aborts the run with no done pulse.
    force0 = 1'b1;
    kick(0, 0, 0, 0, 0, 0);
    repeat (5) tick();
    chk("abort_busy_pre", int'(busy_a[0]), 1);
    chk("abort_mcnt_pre", mcnt_of(0), 2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_busy", int'(busy_a[0]), 0);
    chk("abort_mcnt", mcnt_of(0), 0);
    chk("abort_done", int'(done_a[0]), 0);
    nd = 0;
    repeat (20) begin
      tick();
      if (done_a[0] === 1'b1) nd++;
    end
    chk("abort_no_done", nd, 0);
    force0 = 1'b0;

    // Reset wins over a simultaneous start.
    rst_n = 1'b0;
    start_a[0] = 1'b1;
    tick();
    start_a[0] = 1'b0;
    rst_n = 1'b1;
    chk("rst_over_start", int'(busy_a[0]), 0);
    kick(0, 18, 0, 1, 0, 1);
    wait_done("post_rst");

    // LATENCY=3 with a repeated start during CHECK that must be ignored.
    kick(2, 20, 0, 1, 0, 1);
    repeat (6) tick();
    start_a[2] = 1'b1;
    tick();
    start_a[2] = 1'b0;
    wait_done("lat3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ff_response_checker.md
FF_RESPONSE_CHECKER -- requirements
Module: ff_response_checker

Interface
REQ-001 The module SHALL have parameter NUM_SAMPLES, default 16, giving the number of compared cycles per run (legal range 1..255).
REQ-002 The module SHALL have parameter LATENCY, default 1, giving the expected DUT delay in clock cycles from d_ref to q_in (legal range 1..4).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The module SHALL have port start, input, 1 bit: a one-cycle request to begin a run.
REQ-006 The module SHALL have port d_ref, input, 1 bit: the stimulus bit the bench is driving into the flip-flop under test.
REQ-007 The module SHALL have port q_in, input, 1 bit: the q response of the flip-flop under test.
REQ-008 The module SHALL have port qbar_in, input, 1 bit: the qbar response of the flip-flop under test.
REQ-009 The module SHALL have port busy, output, 1 bit: high in the ARM and CHECK states.
REQ-010 The module SHALL have port done, output, 1 bit: a one-cycle pulse at the end of a run.
REQ-011 The module SHALL have port pass, output, 1 bit: the result of the last completed run.
REQ-012 The module SHALL have port mismatch_cnt, output, 8 bits: the number of q mismatches in the current or last run.
REQ-013 The module SHALL have port cmp_err, output, 1 bit: sticky flag, set when q_in equals qbar_in.

Function
REQ-014 The module SHALL implement FSM states IDLE, ARM, CHECK and DONE.
REQ-015 The FSM SHALL move from IDLE to ARM when start=1; in that same transition it SHALL clear mismatch_cnt, cmp_err, pass and the sample counter.
REQ-016 In every state, d_ref SHALL be shifted into a LATENCY-deep expected-value pipeline; the pipeline output is exp_q.
REQ-017 The FSM SHALL stay in ARM for exactly LATENCY cycles, performing no comparisons, and then move to CHECK.
REQ-018 In each CHECK cycle, if q_in differs from exp_q, mismatch_cnt SHALL increment, saturating at 255 with no wrap.
REQ-019 In each CHECK cycle the 8-bit sample counter SHALL increment; when it reaches NUM_SAMPLES the FSM SHALL move to DONE, so that exactly NUM_SAMPLES cycles are compared.
REQ-020 DONE SHALL last one cycle, with done=1 in that cycle; pass SHALL register (mismatch_cnt==0 and cmp_err==0), including any mismatch found in the final CHECK cycle; the FSM SHALL then return to IDLE.
REQ-021 start SHALL be ignored in ARM, CHECK and DONE; start in the IDLE cycle that follows DONE SHALL begin a new run.
REQ-022 pass and mismatch_cnt SHALL hold their values in IDLE until the next start.
REQ-023 Latency from the first CHECK cycle to done SHALL be NUM_SAMPLES cycles; from the start cycle to done it SHALL be LATENCY+NUM_SAMPLES+1 cycles.

Reset
REQ-024 When rst_n=0 at a rising clk edge, the FSM SHALL go to IDLE, and busy, done, pass, cmp_err, mismatch_cnt, the sample counter and the expected-value pipeline SHALL all become 0.
REQ-025 Reset asserted mid-run SHALL abort the run without producing a done pulse.
REQ-026 rst_n=0 SHALL take priority over start in the same cycle.

Configuration
REQ-027 The module SHALL provide a compile-time feature controlled by the macro FF_RESPONSE_CHECKER_QBAR_CHECK_EN.
REQ-028 With FF_RESPONSE_CHECKER_QBAR_CHECK_EN defined, cmp_err SHALL be set in any CHECK cycle where qbar_in equals q_in, and SHALL stay set until the next start or reset.
REQ-029 Without FF_RESPONSE_CHECKER_QBAR_CHECK_EN defined, cmp_err SHALL be tied to 0, qbar_in SHALL be unused, and pass SHALL depend only on mismatch_cnt.

Verification
REQ-030 The bench SHALL cover: defaults, ideal DFF, d_ref toggling every 2 cycles, start pulsed -> done exactly 18 cycles after start, pass=1, mismatch_cnt=0.
REQ-031 The bench SHALL cover: q_in forced to 0 while d_ref toggles, NUM_SAMPLES=16 -> mismatch_cnt=8 at done, pass=0.
REQ-032 The bench SHALL cover: NUM_SAMPLES=255, q_in=~exp_q throughout -> mismatch_cnt saturates at 255 and does not wrap, pass=0.
REQ-033 The bench SHALL cover: macro defined, qbar_in tied equal to q_in for 1 CHECK cycle -> cmp_err=1 sticky, pass=0; macro undefined, same stimulus -> cmp_err=0, pass=1.
REQ-034 The bench SHALL cover: rst_n=0 on the 5th CHECK cycle -> the next cycle shows busy=0, mismatch_cnt=0, no done pulse; a new start then completes normally.
REQ-035 The bench SHALL cover: LATENCY=3, ideal 3-stage-delayed q_in, start repeated during CHECK -> the repeated start is ignored, done arrives exactly 20 cycles after the first start, and pass=1.
